// File: rtl/ms_to_hms_decoder_pkg.sv
// Shared constants, FSM state encoding and BCD helper for the centisecond-to-d/h/m/s/cs decoder.
package ms_to_hms_decoder_pkg;

    localparam int CNT_W        = 32;
    localparam int DAYS_W       = 10;
    localparam int BCD_W        = 8;
    localparam int CONV_LATENCY = 130;

    localparam logic [BCD_W-1:0] DIV_CENTI = 8'd100;
    localparam logic [BCD_W-1:0] DIV_SEC   = 8'd60;
    localparam logic [BCD_W-1:0] DIV_MIN   = 8'd60;
    localparam logic [BCD_W-1:0] DIV_HOUR  = 8'd24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_BCD,
        ST_DONE
    } state_t;

    // Two packed BCD digits; callers guarantee v < 100.
    function automatic logic [BCD_W-1:0] to_bcd(input logic [BCD_W-1:0] v);
        return BCD_W'(((v / 8'd10) << 4) | (v % 8'd10));
    endfunction

endpackage

// File: rtl/ms_to_hms_decoder_seq_const_div_step.sv
// One restoring shift-subtract division iteration: shifts the next dividend bit into the
// partial remainder and subtracts the divisor when it fits. Purely combinational.
module seq_const_div_step
    import ms_to_hms_decoder_pkg::*;
(
    input  logic [BCD_W-1:0] i_rem,
    input  logic             i_qbit,
    input  logic [BCD_W-1:0] i_divisor,
    output logic [BCD_W-1:0] o_rem,
    output logic             o_qbit
);

    logic [BCD_W:0] w_trial;
    logic [BCD_W:0] w_diff;

    // Remainder stays below the divisor (<=100), so the trial is <200 and a 9-bit
    // subtraction wraps into bit 8 exactly when the divisor does not fit.
    assign w_trial = {i_rem, i_qbit};
    assign w_diff  = w_trial - {1'b0, i_divisor};
    assign o_qbit  = ~w_diff[BCD_W];
    assign o_rem   = o_qbit ? w_diff[BCD_W-1:0] : w_trial[BCD_W-1:0];

endmodule

// File: rtl/ms_to_hms_decoder.sv
// Converts a centisecond tick count into binary days plus BCD hours/minutes/seconds/centis
// using one shared shift-subtract divider stepped through /100, /60, /60, /24.
module ms_to_hms_decoder
    import ms_to_hms_decoder_pkg::*;
#(
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clockSignal,
    input  logic                   reset,
    input  logic                   startConvert,
    input  logic [COUNT_WIDTH-1:0] countValue,
    output logic                   busy,
    output logic                   convertDone,
    output logic [DAYS_W-1:0]      daysOut,
    output logic [BCD_W-1:0]       hoursBcd,
    output logic [BCD_W-1:0]       minutesBcd,
    output logic [BCD_W-1:0]       secondsBcd,
    output logic [BCD_W-1:0]       centisBcd
);

    localparam int         CONV_CYCLES = CONV_LATENCY;
    // Latency = capture edge + one load cycle + 128 iterations + BCD cycle.
    localparam logic [6:0] LAST_ITER   = 7'(CONV_CYCLES - 3);

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_quo;
    logic [BCD_W-1:0]  r_rem;
    logic [BCD_W-1:0]  r_rem_cs;
    logic [BCD_W-1:0]  r_rem_s;
    logic [BCD_W-1:0]  r_rem_m;
    logic [BCD_W-1:0]  r_rem_h;
    logic [6:0]        r_iter;
    logic              r_load;
    logic [DAYS_W-1:0] r_days;
    logic [BCD_W-1:0]  r_hours;
    logic [BCD_W-1:0]  r_mins;
    logic [BCD_W-1:0]  r_secs;
    logic [BCD_W-1:0]  r_centis;

    logic [1:0]        w_pass;
    logic [4:0]        w_step;
    logic [BCD_W-1:0]  w_divisor;
    logic [BCD_W-1:0]  w_rem_in;
    logic [BCD_W-1:0]  w_rem_next;
    logic              w_qbit;

    assign w_pass   = r_iter[6:5];
    assign w_step   = r_iter[4:0];
    // Each pass restarts with an empty remainder; the quotient register already holds the next dividend.
    assign w_rem_in = (w_step == 5'd0) ? '0 : r_rem;

    always_comb begin
        w_divisor = DIV_CENTI;
        case (w_pass)
            2'd0:    w_divisor = DIV_CENTI;
            2'd1:    w_divisor = DIV_SEC;
            2'd2:    w_divisor = DIV_MIN;
            default: w_divisor = DIV_HOUR;
        endcase
    end

    seq_const_div_step u_step (
        .i_rem     (w_rem_in),
        .i_qbit    (r_quo[CNT_W-1]),
        .i_divisor (w_divisor),
        .o_rem     (w_rem_next),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clockSignal) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (startConvert) w_next = ST_DIV;
            ST_DIV:  if (!r_load && (r_iter == LAST_ITER)) w_next = ST_BCD;
            ST_BCD:  w_next = ST_DONE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clockSignal) begin
        if (reset) begin
            r_count  <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
            r_rem_cs <= '0;
            r_rem_s  <= '0;
            r_rem_m  <= '0;
            r_rem_h  <= '0;
            r_iter   <= '0;
            r_load   <= 1'b0;
            r_days   <= '0;
            r_hours  <= '0;
            r_mins   <= '0;
            r_secs   <= '0;
            r_centis <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (startConvert) begin
                        r_count <= CNT_W'(countValue);
                        r_load  <= 1'b1;
                        r_iter  <= '0;
                    end
                end
                ST_DIV: begin
                    if (r_load) begin
                        r_quo  <= r_count;
                        r_load <= 1'b0;
                    end else begin
                        r_quo  <= {r_quo[CNT_W-2:0], w_qbit};
                        r_rem  <= w_rem_next;
                        r_iter <= r_iter + 7'd1;
                        if (w_step == 5'd31) begin
                            case (w_pass)
                                2'd0:    r_rem_cs <= w_rem_next;
                                2'd1:    r_rem_s  <= w_rem_next;
                                2'd2:    r_rem_m  <= w_rem_next;
                                default: r_rem_h  <= w_rem_next;
                            endcase
                        end
                    end
                end
                ST_BCD: begin
                    r_days   <= r_quo[DAYS_W-1:0];
                    r_hours  <= to_bcd(r_rem_h);
                    r_mins   <= to_bcd(r_rem_m);
                    r_secs   <= to_bcd(r_rem_s);
                    r_centis <= to_bcd(r_rem_cs);
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign convertDone = (r_state == ST_DONE);
    assign daysOut     = r_days;
    assign hoursBcd    = r_hours;
    assign minutesBcd  = r_mins;
    assign secondsBcd  = r_secs;
    assign centisBcd   = r_centis;

endmodule

// File: doc/ms_to_hms_decoder.md
MS_TO_HMS_DECODER -- requirements
Module: ms_to_hms_decoder

Interface
REQ-001 SHALL have parameter COUNT_WIDTH, default 32, meaning width of the input tick count (legal range 8..32).
REQ-002 SHALL have parameter CONV_CYCLES, default 130, meaning fixed start-to-done latency in clocks; informational only, not overridable.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clockSignal  input  1  system clock; one tick = 10 ms, the 100 Hz timebase of the counter block.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 startConvert  input  1  request; sampled only in IDLE.
REQ-007 countValue  input  COUNT_WIDTH  unsigned centisecond count from the timer/stopwatch counter.
REQ-008 busy  output  1  high whenever the state is not IDLE.
REQ-009 convertDone  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
REQ-010 daysOut  output  10  binary whole days.
REQ-011 hoursBcd  output  8  two BCD digits, 00..23.
REQ-012 minutesBcd  output  8  two BCD digits, 00..59.
REQ-013 secondsBcd  output  8  two BCD digits, 00..59.
REQ-014 centisBcd  output  8  two BCD digits, 00..99.

Function
REQ-015 SHALL implement FSM states IDLE, DIV, BCD and DONE.
REQ-016 IDLE->DIV when startConvert=1; countValue SHALL be zero-extended to 32 bits and captured on that edge.
REQ-017 In DIV the block SHALL perform four sequential shift-subtract divisions of 32 iterations each, one iteration per clock (128 clocks total).
- Division chain: /100, /60, /60, /24.
- Each quotient feeds the next division.
- The remainders are centiseconds, seconds, minutes and hours, in that order.
- The final quotient is days.
REQ-018 DIV->BCD after iteration 128; BCD SHALL convert each remainder (<100) to tens/ones digits in one clock.
REQ-019 BCD->DONE; all result outputs SHALL update on the edge entering DONE.
REQ-020 DONE->IDLE unconditionally after one cycle.
- convertDone=1 only in DONE.
- convertDone SHALL rise exactly CONV_CYCLES (130) clocks after the edge that sampled startConvert.
REQ-021 startConvert SHALL be ignored in DIV, BCD and DONE; no queuing.
REQ-022 A start in the cycle immediately after DONE SHALL be accepted, so back-to-back conversions occur every 131 clocks.
REQ-023 Result outputs SHALL hold their last values between conversions.
REQ-024 Changes on countValue after capture SHALL NOT affect the conversion in progress.
REQ-025 The maximum input 2^32-1 SHALL yield daysOut=497, so no overflow path exists; daysOut is the low 10 bits of the final quotient.
REQ-026 Divider width rules:
- Partial remainders are 8 bits, which suffices for divisor 100.
- The subtraction is 9 bits wide.
- The quotient register is 32 bits.

Reset
REQ-027 reset=1 SHALL force IDLE on the next edge from any state, including mid-DIV.
- busy and convertDone go to 0.
- All result outputs go to 0.
- The captured count and divider registers are cleared.
REQ-028 reset SHALL take priority over startConvert in the same cycle.
REQ-029 No initial blocks SHALL be relied on for state.

Structure
REQ-030 A shared package SHALL hold:
- the divisor constants 100, 60, 60 and 24;
- the width constants: 32 (count), 10 (days), 8 (BCD field);
- the 130-cycle latency constant;
- the FSM state enum.
REQ-031 One sub-module, seq_const_div_step, SHALL implement a single shift-subtract iteration (remainder, quotient bit, divisor in; next remainder and quotient out).
- The top level instantiates it once.
- The top level muxes the divisor per pass.

Verification
REQ-032 countValue=0, start pulse -> convertDone at +130 clocks; all outputs 0.
REQ-033 countValue=366100 -> daysOut=0, hoursBcd=8'h01, minutesBcd=8'h01, secondsBcd=8'h01, centisBcd=8'h00.
REQ-034 Day boundary check:
- countValue=8639999 -> daysOut=0, hours 8'h23, minutes 8'h59, seconds 8'h59, centis 8'h99.
- Then countValue=8640000 -> daysOut=1, all BCD fields 8'h00.
REQ-035 countValue=32'hFFFFFFFF -> daysOut=497, hours 8'h02, minutes 8'h27, seconds 8'h52, centis 8'h95.
REQ-036 Start with 366100, then pulse start with 0 at +50 clocks, and change countValue to 0 mid-DIV -> single convertDone at +130 with the REQ-033 result; busy stays high throughout.
REQ-037 Reset asserted at +60 clocks of a conversion -> next cycle busy=0 and outputs 0; no convertDone; a new start afterwards completes normally in 130 clocks.
